// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//  WORD_W     : data word width (bits)
//  state_t    : responder FSM states
//  word_index : byte address -> word address (drops the two byte-offset bits)
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_BURST = 2'd2,
    WR_WAIT  = 2'd3
  } state_t;

  // Callers keep only the low ADDR_W bits, which makes the index wrap
  // modulo the array depth and ignores the upper address bits.
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/mem_array_1r1w.sv
// Backing store: 2**ADDR_W words, one synchronous write port and one
// combinational read port.
//  clk   : rising-edge clock for the write port
//  we    : write enable
//  waddr : write word index
//  wdata : write data
//  raddr : read word index
//  rdata : read data (combinational from raddr)
module mem_array_1r1w
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset; clearing every word would turn the RAM
  // into a huge flop bank, and its contents are meant to survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the data cache's refill / write-through port.
// Accepts one request at a time: a burst read of one cache line or a single
// word write, each delayed by a fixed latency to model main memory.
//  clock         : rising-edge clock
//  reset         : asynchronous, active-low reset
//  readRequest   : one-cycle pulse, start a line read at readAddress
//  readAddress   : byte address of the read (any word of the line)
//  writeRequest  : one-cycle pulse, write writeData at writeAddress
//  writeAddress  : byte address of the write
//  writeData     : word to store
//  busy          : request in flight; new requests only accepted while 0
//  readEnable    : high for each refill beat
//  readBeat      : beat index of the current refill word
//  data_out      : refill word; holds the last beat while readEnable is low
//  writeDone     : one-cycle pulse once the write has landed in the array
//  protocolError : sticky flag, a request arrived while busy (or both at once)
module data_memory_responder
  import mem_pkg::*;
#(
  parameter  int ADDR_W     = 10,
  parameter  int LINE_WORDS = 4,
  parameter  int RD_LATENCY = 8,
  parameter  int WR_LATENCY = 6,
  localparam int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              readRequest,
  input  logic [31:0]       readAddress,
  input  logic              writeRequest,
  input  logic [31:0]       writeAddress,
  input  logic [WORD_W-1:0] writeData,
  output logic              busy,
  output logic              readEnable,
  output logic [BEAT_W-1:0] readBeat,
  output logic [WORD_W-1:0] data_out,
  output logic              writeDone,
  output logic              protocolError
);

  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0]  RD_CNT_INIT = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0]  WR_CNT_INIT = CNT_W'(WR_LATENCY - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK   = ~(ADDR_W'(LINE_WORDS - 1));

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [29:0]         rd_word, wr_word;
  logic [ADDR_W-1:0]   rd_base;
  logic [ADDR_W-1:0]   mem_raddr;
  logic [WORD_W-1:0]   mem_rdata;
  logic                mem_we;
  logic                unused_upper;

  assign rd_word      = word_index(readAddress);
  assign wr_word      = word_index(writeAddress);
  assign rd_base      = rd_word[ADDR_W-1:0] & LINE_MASK;
  assign unused_upper = ^{rd_word[29:ADDR_W], wr_word[29:ADDR_W]};

  // The base is line-aligned, so OR-ing the beat in walks the line and can
  // never carry into the next one.
  assign mem_raddr = base_q | ADDR_W'(beat_q);
  assign mem_we    = (state_q == WR_WAIT) && (cnt_q == '0);

  mem_array_1r1w #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clock),
    .we    (mem_we),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // The writeDone cycle still counts as busy: the FSM is already back in
  // IDLE, but the handshake ends only the cycle after the pulse.
  assign busy          = (state_q != IDLE) || done_q;
  assign readEnable    = (state_q == RD_BURST);
  assign readBeat      = beat_q;
  assign data_out      = readEnable ? mem_rdata : hold_q;
  assign writeDone     = done_q;
  assign protocolError = err_q;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    base_d    = base_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    err_d     = err_q;

    if (busy && (readRequest || writeRequest)) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (!done_q) begin
          if (writeRequest) begin
            wr_addr_d = wr_word[ADDR_W-1:0];
            wr_data_d = writeData;
            cnt_d     = WR_CNT_INIT;
            state_d   = WR_WAIT;
            // The cache must never issue both; the read is dropped.
            if (readRequest) err_d = 1'b1;
          end else if (readRequest) begin
            base_d  = rd_base;
            cnt_d   = RD_CNT_INIT;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          beat_d  = '0;
          state_d = RD_BURST;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_BURST: begin
        hold_d = mem_rdata;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      base_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder. A word-addressed array
// mirrors the memory; latencies and beat positions come from plain
// arithmetic on the request cycle.
module tb_data_memory_responder;

  localparam int ADDR_W = 10;
  localparam int LW     = 4;
  localparam int RD_LAT = 8;
  localparam int WR_LAT = 6;
  localparam int DEPTH  = 1 << ADDR_W;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        readRequest = 1'b0;
  logic [31:0] readAddress = '0;
  logic        writeRequest = 1'b0;
  logic [31:0] writeAddress = '0;
  logic [31:0] writeData = '0;
  logic        busy;
  logic        readEnable;
  logic [1:0]  readBeat;
  logic [31:0] data_out;
  logic        writeDone;
  logic        protocolError;

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [DEPTH];

  data_memory_responder #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LW),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .readRequest   (readRequest),
    .readAddress   (readAddress),
    .writeRequest  (writeRequest),
    .writeAddress  (writeAddress),
    .writeData     (writeData),
    .busy          (busy),
    .readEnable    (readEnable),
    .readBeat      (readBeat),
    .data_out      (data_out),
    .writeDone     (writeDone),
    .protocolError (protocolError)
  );

  always #5 clock = ~clock;

  function automatic int word_of(input logic [31:0] addr);
    return int'(addr >> 2) % DEPTH;
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Write transaction; optionally raises readRequest in the same cycle.
  task automatic run_write(input logic [31:0] addr, input logic [31:0] data,
                           input bit with_read, input bit exp_err, input string tag);
    writeAddress = addr;
    writeData    = data;
    writeRequest = 1'b1;
    if (with_read) begin
      readRequest = 1'b1;
      readAddress = addr ^ 32'h100;
    end
    next_cycle();
    writeRequest = 1'b0;
    readRequest  = 1'b0;
    for (int cyc = 1; cyc <= WR_LAT + 2; cyc++) begin
      checks++;
      if (writeDone !== (cyc == WR_LAT + 1)) begin
        errors++;
        $display("FAIL %s write_done cyc=%0d got=%b exp=%b", tag, cyc, writeDone, cyc == WR_LAT + 1);
      end
      checks++;
      if (busy !== (cyc <= WR_LAT + 1)) begin
        errors++;
        $display("FAIL %s write_busy cyc=%0d got=%b exp=%b", tag, cyc, busy, cyc <= WR_LAT + 1);
      end
      checks++;
      if (readEnable !== 1'b0) begin
        errors++;
        $display("FAIL %s write_no_beat cyc=%0d got=%b exp=0", tag, cyc, readEnable);
      end
      if (cyc < WR_LAT + 2) next_cycle();
    end
    checks++;
    if (protocolError !== exp_err) begin
      errors++;
      $display("FAIL %s write_perr got=%b exp=%b", tag, protocolError, exp_err);
    end
    ref_mem[word_of(addr)] = data;
  endtask

  // Line read; poke_cyc != 0 injects an illegal readRequest in that cycle.
  task automatic run_read(input logic [31:0] addr, input int poke_cyc,
                          input bit exp_err, input string tag);
    int base;
    int last;
    bit en;
    int b;
    base = (word_of(addr) / LW) * LW;
    last = RD_LAT + 1 + LW;
    readAddress = addr;
    readRequest = 1'b1;
    next_cycle();
    readRequest = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      if (poke_cyc != 0 && cyc == poke_cyc + 1) readRequest = 1'b0;
      en = (cyc >= RD_LAT + 1) && (cyc < last);
      b  = cyc - (RD_LAT + 1);
      checks++;
      if (readEnable !== en) begin
        errors++;
        $display("FAIL %s read_en cyc=%0d got=%b exp=%b", tag, cyc, readEnable, en);
      end
      checks++;
      if (busy !== (cyc < last)) begin
        errors++;
        $display("FAIL %s read_busy cyc=%0d got=%b exp=%b", tag, cyc, busy, cyc < last);
      end
      checks++;
      if (writeDone !== 1'b0) begin
        errors++;
        $display("FAIL %s read_no_done cyc=%0d got=%b exp=0", tag, cyc, writeDone);
      end
      if (en) begin
        checks++;
        if (readBeat !== 2'(b)) begin
          errors++;
          $display("FAIL %s read_beat cyc=%0d got=%0d exp=%0d", tag, cyc, readBeat, b);
        end
        checks++;
        if (data_out !== ref_mem[base + b]) begin
          errors++;
          $display("FAIL %s read_data beat=%0d got=%h exp=%h", tag, b, data_out, ref_mem[base + b]);
        end
      end
      if (cyc == last) begin
        checks++;
        if (data_out !== ref_mem[base + LW - 1]) begin
          errors++;
          $display("FAIL %s read_hold got=%h exp=%h", tag, data_out, ref_mem[base + LW - 1]);
        end
      end
      if (poke_cyc != 0 && cyc == poke_cyc) begin
        readRequest = 1'b1;
        readAddress = addr + 32'h200;
      end
      if (cyc < last) next_cycle();
    end
    checks++;
    if (protocolError !== exp_err) begin
      errors++;
      $display("FAIL %s read_perr got=%b exp=%b", tag, protocolError, exp_err);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy, readEnable, readBeat, data_out, writeDone, protocolError} !== '0) begin
      errors++;
      $display("FAIL %s outputs_zero got busy=%b en=%b beat=%0d data=%h done=%b perr=%b exp=all0",
               tag, busy, readEnable, readBeat, data_out, writeDone, protocolError);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    readRequest = 1'b0;
    writeRequest = 1'b0;
    repeat (3) next_cycle();
    check_all_zero("reset_hold");
    @(negedge clock);
    reset = 1'b1;
    next_cycle();
    check_all_zero("reset_release");
  endtask

  task automatic test_spec_read();
    for (int i = 0; i < LW; i++)
      run_write(32'h20 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, "preload8");
    run_read(32'h24, 0, 1'b0, "spec_read");
  endtask

  task automatic test_write_then_read();
    for (int i = 0; i < LW; i++)
      run_write(32'h40 + 32'(4 * i), $urandom, 1'b0, 1'b0, "preload16");
    run_write(32'h40, 32'hDEADBEEF, 1'b0, 1'b0, "write_deadbeef");
    run_read(32'h40, 0, 1'b0, "readback_deadbeef");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < LW; i++)
      run_write(32'h0000_0FF0 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0, "preload1020");
    run_read(32'hFFFF_FFF0, 0, 1'b0, "wrap_read");
  endtask

  // Fills words 0..63, then random reads/writes with random upper bits.
  task automatic test_random();
    logic [31:0] a;
    for (int w = 0; w < 64; w++)
      run_write(32'(w * 4), $urandom, 1'b0, 1'b0, "fill");
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      a[11:8] = 4'h0;
      if ($urandom_range(0, 2) == 0) run_write(a, $urandom, 1'b0, 1'b0, "rand_write");
      else                           run_read(a, 0, 1'b0, "rand_read");
    end
  endtask

  task automatic test_read_while_busy();
    run_read(32'h34, 2, 1'b1, "read_while_busy");
  endtask

  task automatic test_reset_mid_burst();
    readAddress = 32'h18;
    readRequest = 1'b1;
    next_cycle();
    readRequest = 1'b0;
    repeat (RD_LAT + 1) next_cycle();
    checks++;
    if (readEnable !== 1'b1 || readBeat !== 2'd1) begin
      errors++;
      $display("FAIL mid_burst_beat1 got en=%b beat=%0d exp en=1 beat=1", readEnable, readBeat);
    end
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_burst");
    for (int i = 0; i < LW + 1; i++) begin
      next_cycle();
      if (i == 1) reset = 1'b1;
      checks++;
      if (readEnable !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL after_abort cyc=%0d got en=%b busy=%b exp en=0 busy=0", i, readEnable, busy);
      end
    end
    run_read(32'h58, 0, 1'b0, "read_after_abort");
  endtask

  task automatic test_both_requests();
    run_write(32'h64, 32'h1234_5678, 1'b1, 1'b1, "both_requests");
    run_read(32'h64, 0, 1'b1, "both_readback");
  endtask

  initial begin
    test_reset();
    test_spec_read();
    test_write_then_read();
    test_wrap();
    test_random();
    test_read_while_busy();
    test_reset_mid_burst();
    test_both_requests();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
